// File: rtl/axis_pattern_gen.sv
// AXI-Stream test pattern generator: emits frames of COLS x ROWS beats in one of
// four data patterns, for a fixed number of frames or continuously until stopped.
module axis_pattern_gen #(
  parameter int          DATA_W = 64,
  parameter int          COLS   = 1024,
  parameter int          ROWS   = 1,
  parameter logic [63:0] SEED   = 64'h399784ec
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [15:0]       num_frames,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start; stream outputs low
  // RUN   | streaming beats, tvalid held high throughout
  // DONE  | one-cycle done pulse, then back to IDLE

  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int HW = DATA_W / 2;
  localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);
  localparam logic [XW-1:0]     X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d, nx;
  logic [YW-1:0]       y_q, y_d, ny;
  logic [DATA_W-1:0]   beat_q, beat_d, nb;
  logic [15:0]         frame_q, frame_d, frame_inc;
  logic [15:0]         nf_q, nf_d;
  logic [1:0]          mode_q, mode_d;
  logic                stop_q, stop_d;
  logic [DATA_W-1:0]   tdata_d;
  logic                tvalid_d, tuser_d, tlast_d;
  logic                beat_fire, frame_end, last_frame;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [XW-1:0]     px,
                                                input logic [YW-1:0]     py,
                                                input logic [DATA_W-1:0] pb);
    logic [DATA_W-1:0] r;
    r = '0;
    case (m)
      2'd0:    r = SEED_W;
      2'd1:    r = SEED_W + pb;
      2'd2:    r = {HW'(py), HW'(px)};
      default: r = {DATA_W{px[0] ^ py[0]}};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      beat_q        <= '0;
      frame_q       <= '0;
      nf_q          <= '0;
      mode_q        <= '0;
      stop_q        <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      beat_q        <= beat_d;
      frame_q       <= frame_d;
      nf_q          <= nf_d;
      mode_q        <= mode_d;
      stop_q        <= stop_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tuser  <= tuser_d;
      m_axis_tlast  <= tlast_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    beat_d    = beat_q;
    frame_d   = frame_q;
    nf_d      = nf_q;
    mode_d    = mode_q;
    stop_d    = stop_q;
    tdata_d   = m_axis_tdata;
    tvalid_d  = m_axis_tvalid;
    tuser_d   = m_axis_tuser;
    tlast_d   = m_axis_tlast;
    beat_fire = m_axis_tvalid & m_axis_tready;
    frame_end = (x_q == X_LAST) && (y_q == Y_LAST);
    frame_inc = frame_q + 16'd1;
    last_frame = ((nf_q != 16'd0) && (frame_inc == nf_q)) || stop_q || stop;
    nx = (x_q == X_LAST) ? '0 : x_q + XW'(1);
    ny = (x_q == X_LAST) ? ((y_q == Y_LAST) ? '0 : y_q + YW'(1)) : y_q;
    nb = frame_end ? '0 : beat_q + DATA_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          mode_d   = mode;
          nf_d     = num_frames;
          x_d      = '0;
          y_d      = '0;
          beat_d   = '0;
          frame_d  = '0;
          stop_d   = 1'b0;
          tvalid_d = 1'b1;
          tuser_d  = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = pattern(mode, '0, '0, '0);
        end
      end
      S_RUN: begin
        if (stop) stop_d = 1'b1;
        if (beat_fire) begin
          x_d    = nx;
          y_d    = ny;
          beat_d = nb;
          if (frame_end) frame_d = frame_inc;
          // Output registers already hold the next beat, so the last handshake
          // drops tvalid directly rather than presenting a dead beat.
          if (frame_end && last_frame) begin
            state_d  = S_DONE;
            tvalid_d = 1'b0;
            tuser_d  = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            tvalid_d = 1'b1;
            tuser_d  = (nx == '0) && (ny == '0);
            tlast_d  = (nx == X_LAST);
            tdata_d  = pattern(mode_q, nx, ny, nb);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: doc/axis_pattern_gen.md
AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 64, tdata width in bits (even, >= 32).
REQ-002 SHALL have parameter COLS, default 1024, beats per line (>= 2).
REQ-003 SHALL have parameter ROWS, default 1, lines per frame (>= 1).
REQ-004 SHALL have parameter SEED, default 64'h399784ec, base data value, truncated to DATA_W.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  level; sampled only in IDLE.
REQ-008 SHALL have port stop  input  1  request to end after the current frame.
REQ-009 SHALL have port mode  input  2  pattern select; latched on start.
REQ-010 SHALL have port num_frames  input  16  frames to send; 0 = continuous; latched on start.
REQ-011 SHALL have port m_axis_tdata  output  DATA_W  stream data.
REQ-012 SHALL have port m_axis_tvalid  output  1  stream valid.
REQ-013 SHALL have port m_axis_tready  input  1  stream ready.
REQ-014 SHALL have port m_axis_tuser  output  1  start of frame.
REQ-015 SHALL have port m_axis_tlast  output  1  end of line.
REQ-016 SHALL have port busy  output  1  high in states other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at sequence end.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 SHALL move IDLE->RUN on the first clk edge with start=1, and SHALL latch mode, num_frames, and clear x, y, frame_cnt and beat_cnt.
REQ-020 SHALL register all stream outputs; first valid beat appears on the cycle after the start edge.
REQ-021 SHALL hold tvalid=1 for the entire RUN state, with no bubbles between beats, lines or frames.
REQ-022 SHALL hold tdata/tuser/tlast stable while tvalid=1 and tready=0; a beat completes only when tvalid and tready are both 1.
REQ-023 SHALL keep x in 0..COLS-1 and y in 0..ROWS-1; on each beat x++; at x=COLS-1, x wraps to 0 and y++; at y=ROWS-1, y wraps to 0.
REQ-024 SHALL drive tuser=1 exactly when x=0 and y=0; tlast=1 exactly when x=COLS-1.
REQ-025 SHALL set tdata as follows. mode 0: SEED. mode 1: SEED+beat_cnt modulo 2^DATA_W, with beat_cnt restarting at 0 each frame. mode 2: {y zero-extended to DATA_W/2, x zero-extended to DATA_W/2}. mode 3: all ones if x[0]^y[0]=1, else all zeros.
REQ-026 SHALL increment frame_cnt (16 bit) on the last beat of a frame (x=COLS-1, y=ROWS-1).
REQ-027 SHALL go RUN->DONE on the last beat of a frame when num_frames!=0 and frame_cnt+1=num_frames, or when stop has been seen.
REQ-028 SHALL register stop as sticky from the first cycle it is seen in RUN; stop never truncates a frame mid-way.
REQ-029 SHALL, on the edge completing the final beat, clear tvalid, tuser and tlast.
REQ-030 SHALL assert done for exactly one cycle in DONE, then go to IDLE; start is ignored in DONE.
REQ-031 SHALL let continuous mode (num_frames=0) wrap frame_cnt at 16 bits without terminating.
REQ-032 SHALL ignore changes to mode and num_frames during RUN.
REQ-033 SHALL, with COLS=2 and ROWS=1, put tuser and tlast on alternate beats with no gap.

Reset
REQ-034 SHALL, on resetn=0, immediately (asynchronously) enter IDLE and drive tvalid=0, tuser=0, tlast=0, tdata=0, busy=0, done=0, and clear all counters and the stop flag.
REQ-035 SHALL, on reset mid-frame, drop the partial frame; the next start begins a fresh frame with tuser=1.
REQ-036 SHALL release reset synchronously: the first state change occurs on the first clk edge after resetn rises.

Verification
REQ-037 SHALL cover: COLS=4, ROWS=2, mode 1, num_frames=1, tready=1 -> 8 beats of tdata SEED+0..SEED+7; tuser on beat 0; tlast on beats 3 and 7; done one cycle later.
REQ-038 SHALL cover: mode 2, COLS=4, ROWS=2 -> tdata low half 0,1,2,3,0,1,2,3; high half 0,0,0,0,1,1,1,1.
REQ-039 SHALL cover: random tready toggling, num_frames=3 -> exactly 24 accepted beats; stable payload while stalled; 3 tuser; one done.
REQ-040 SHALL cover: num_frames=0, stop pulsed at beat 5 of frame 2 -> frame 2 completes; 16 beats total; then done.
REQ-041 SHALL cover: resetn low at beat 3 with tready=0 -> outputs go 0 without a clock edge; restart gives tuser=1 with tdata=SEED (mode 1).
REQ-042 SHALL cover: mode 3, COLS=4, ROWS=2 -> row 0 data 0,F..F,0,F..F; row 1 data F..F,0,F..F,0.
